// File: rtl/shield_damage_scheduler.sv
// Latches shield hit/kill requests, arbitrates kill > player > bomb, and streams a 13-cell crater erase, one cell per clock.
// Latency: pulse at t gives writes t+2..t+14 and hitDone at t+15; a request arriving while its latch is full is dropped.
module shield_damage_scheduler #(
    parameter int CRATER_RADIUS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        playGame,
    input  logic        killReq,
    input  logic [10:0] killX,
    input  logic        playerHitReq,
    input  logic [10:0] playerHitX,
    input  logic [10:0] playerHitY,
    input  logic        bombHitReq,
    input  logic [10:0] bombHitX,
    input  logic [10:0] bombHitY,
    output logic        wrEn,
    output logic [1:0]  wrShield,
    output logic [3:0]  wrRow,
    output logic [4:0]  wrCol,
    output logic [3:0]  shieldLive,
    output logic        busy,
    output logic        hitDone,
    output logic        dropped
);
    typedef enum logic [1:0] {S_IDLE, S_KILL, S_ERASE, S_DONE} state_t;

    localparam logic [3:0] LAST_STEP = 4'(2 * CRATER_RADIUS * (CRATER_RADIUS + 1));
    localparam logic [2:0] M2 = 3'b110, M1 = 3'b111, Z0 = 3'b000, P1 = 3'b001, P2 = 3'b010;

    state_t      state, state_nxt;
    logic [3:0]  step;
    logic        rst_all;
    logic        kill_vld, kill_ok;
    logic [1:0]  kill_sh;
    logic        ply_vld, ply_ok, bomb_vld, bomb_ok;
    logic [1:0]  ply_sh, bomb_sh;
    logic [3:0]  ply_row, bomb_row;
    logic [4:0]  ply_col, bomb_col;
    logic        cur_ok;
    logic [1:0]  cur_sh;
    logic [3:0]  cur_row;
    logic [4:0]  cur_col;
    logic        take_kill, take_ply, take_bomb;
    logic        hit_ok;
    logic [1:0]  hit_sh, base_sh;
    logic [3:0]  hit_row, base_row, cell_idx;
    logic [4:0]  hit_col, base_col;
    logic [2:0]  d_row, d_col;
    logic [4:0]  row_s;
    logic [5:0]  col_s;
    logic        write_nxt, wr_nxt;
    logic        unused_bits;

    assign rst_all     = reset | ~playGame;
    assign unused_bits = &{killX[5:0], playerHitX[0], playerHitY[0], bombHitX[0], bombHitY[0]};

    always_comb begin
        take_kill = (state == S_IDLE) & kill_vld;
        take_ply  = (state == S_IDLE) & ~kill_vld & ply_vld;
        take_bomb = (state == S_IDLE) & ~kill_vld & ~ply_vld & bomb_vld;
        hit_ok    = ply_vld ? ply_ok  : bomb_ok;
        hit_sh    = ply_vld ? ply_sh  : bomb_sh;
        hit_row   = ply_vld ? ply_row : bomb_row;
        hit_col   = ply_vld ? ply_col : bomb_col;
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take_kill)                  state_nxt = S_KILL;
                else if (take_ply || take_bomb) state_nxt = hit_ok ? S_ERASE : S_DONE;
            end
            S_KILL:  state_nxt = S_DONE;
            S_ERASE: if (step == LAST_STEP) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so the cell computed here is the one shown next cycle.
    always_comb begin
        base_sh  = (state == S_IDLE) ? hit_sh  : cur_sh;
        base_row = (state == S_IDLE) ? hit_row : cur_row;
        base_col = (state == S_IDLE) ? hit_col : cur_col;
        cell_idx = (state == S_IDLE) ? 4'd0 : 4'(step + 4'd1);
        {d_row, d_col} = {Z0, Z0};
        case (cell_idx)
            4'd0:  {d_row, d_col} = {M2, Z0};
            4'd1:  {d_row, d_col} = {M1, M1};
            4'd2:  {d_row, d_col} = {M1, Z0};
            4'd3:  {d_row, d_col} = {M1, P1};
            4'd4:  {d_row, d_col} = {Z0, M2};
            4'd5:  {d_row, d_col} = {Z0, M1};
            4'd6:  {d_row, d_col} = {Z0, Z0};
            4'd7:  {d_row, d_col} = {Z0, P1};
            4'd8:  {d_row, d_col} = {Z0, P2};
            4'd9:  {d_row, d_col} = {P1, M1};
            4'd10: {d_row, d_col} = {P1, Z0};
            4'd11: {d_row, d_col} = {P1, P1};
            4'd12: {d_row, d_col} = {P2, Z0};
            default: {d_row, d_col} = {Z0, Z0};
        endcase
        row_s     = {1'b0, base_row} + {{2{d_row[2]}}, d_row};
        col_s     = {1'b0, base_col} + {{3{d_col[2]}}, d_col};
        write_nxt = (state_nxt == S_ERASE);
        // Sign bit set means the cell fell off the shield edge (including overflow past 15/31).
        wr_nxt    = write_nxt & ~row_s[4] & ~col_s[5];
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state      <= S_IDLE;
            step       <= 4'd0;
            kill_vld   <= 1'b0;
            kill_ok    <= 1'b0;
            kill_sh    <= 2'd0;
            ply_vld    <= 1'b0;
            ply_ok     <= 1'b0;
            ply_sh     <= 2'd0;
            ply_row    <= 4'd0;
            ply_col    <= 5'd0;
            bomb_vld   <= 1'b0;
            bomb_ok    <= 1'b0;
            bomb_sh    <= 2'd0;
            bomb_row   <= 4'd0;
            bomb_col   <= 5'd0;
            cur_ok     <= 1'b0;
            cur_sh     <= 2'd0;
            cur_row    <= 4'd0;
            cur_col    <= 5'd0;
            wrEn       <= 1'b0;
            wrShield   <= 2'd0;
            wrRow      <= 4'd0;
            wrCol      <= 5'd0;
            shieldLive <= 4'b1111;
            busy       <= 1'b0;
            hitDone    <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            state   <= state_nxt;
            step    <= (state == S_ERASE && state_nxt == S_ERASE) ? 4'(step + 4'd1) : 4'd0;
            busy    <= (state_nxt != S_IDLE);
            hitDone <= (state_nxt == S_DONE);
            dropped <= (killReq & kill_vld) | (playerHitReq & ply_vld) | (bombHitReq & bomb_vld);

            if (take_kill) begin
                kill_vld <= 1'b0;
            end else if (killReq && !kill_vld) begin
                kill_vld <= 1'b1;
                kill_ok  <= ~killX[6] & (killX[10:9] == 2'b00);
                kill_sh  <= killX[8:7];
            end
            if (take_ply) begin
                ply_vld <= 1'b0;
            end else if (playerHitReq && !ply_vld) begin
                ply_vld <= 1'b1;
                ply_ok  <= ~playerHitX[6] & (playerHitX[10:9] == 2'b00) & (playerHitY[10:5] == 6'd0);
                ply_sh  <= playerHitX[8:7];
                ply_row <= playerHitY[4:1];
                ply_col <= playerHitX[5:1];
            end
            if (take_bomb) begin
                bomb_vld <= 1'b0;
            end else if (bombHitReq && !bomb_vld) begin
                bomb_vld <= 1'b1;
                bomb_ok  <= ~bombHitX[6] & (bombHitX[10:9] == 2'b00) & (bombHitY[10:5] == 6'd0);
                bomb_sh  <= bombHitX[8:7];
                bomb_row <= bombHitY[4:1];
                bomb_col <= bombHitX[5:1];
            end

            if (take_kill || take_ply || take_bomb) begin
                cur_ok  <= kill_ok;
                cur_sh  <= take_kill ? kill_sh : hit_sh;
                cur_row <= hit_row;
                cur_col <= hit_col;
            end

            wrEn <= wr_nxt;
            if (write_nxt) begin
                wrShield <= base_sh;
                wrRow    <= row_s[3:0];
                wrCol    <= col_s[4:0];
            end

            if (state == S_KILL && cur_ok) shieldLive[cur_sh] <= 1'b0;
        end
    end
endmodule
